wb_cmd_master: RTL and testbench
================================

Name: wb_cmd_master

Overview:
- Wishbone B4 classic single-transfer initiator: the other end of the user-project Wishbone slave port.
- Accepts one read/write command over a valid/ready handshake, runs one CYC/STB cycle, returns data and status over a valid/ready response channel.
- Bounded wait guarded by a timeout watchdog.
- Used as an on-chip bus driver (LA- or core-controlled) and as the bench-side master for slave blocks.

Parameters:
- ADDR_W, 32, Wishbone address width
- DATA_W, 32, Wishbone data width (multiple of 8)
- TIMEOUT, 255, max cycles in BUS state before abort (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write, 0=read
- cmd_addr  in  ADDR_W  target address
- cmd_wdata  in  DATA_W  write data
- cmd_sel  in  DATA_W/8  byte selects
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DATA_W  read data (0 for writes and errors)
- rsp_status  out  2  00 OK, 01 bus error, 10 timeout
- wbm_cyc_o  out  1  Wishbone CYC
- wbm_stb_o  out  1  Wishbone STB
- wbm_we_o  out  1  Wishbone WE
- wbm_sel_o  out  DATA_W/8  Wishbone SEL
- wbm_adr_o  out  ADDR_W  Wishbone address
- wbm_dat_o  out  DATA_W  Wishbone write data
- wbm_dat_i  in  DATA_W  Wishbone read data
- wbm_ack_i  in  1  Wishbone ACK
- wbm_err_i  in  1  Wishbone ERR
- busy  out  1  high in BUS or RESP

Behaviour:
- Reset values: all outputs 0, except cmd_ready=1. State IDLE, timeout counter 0.
- IDLE: cmd_ready=1.
  - On cmd_valid: latch we/addr/wdata/sel into the wbm_* registers, set cyc=stb=1, clear counter, go BUS.
  - The bus cycle starts the edge after acceptance.
- BUS: cmd_ready=0. cyc/stb/adr/dat/sel/we held stable. Counter increments each cycle. Exit conditions, checked in this priority order:
  - wbm_err_i: status 01, rdata 0.
  - wbm_ack_i: status 00; rdata = wbm_dat_i for reads, 0 for writes.
  - counter == TIMEOUT-1 with no ack/err: status 10, rdata 0.
  - On any exit: drop cyc/stb on that same edge, set rsp_valid=1, go RESP.
  - ack and err in the same cycle: err wins.
  - ack on the final timeout cycle: ack wins (OK).
- Latency: a slave that acks one cycle after STB gives rsp_valid 3 edges after command acceptance. cyc/stb is high for exactly 2 cycles.
- RESP: rsp_valid, rsp_rdata and rsp_status held until rsp_ready.
  - On handshake: rsp_valid=0, go IDLE. cmd_ready returns the next cycle, so there is no same-cycle back-to-back accept.
  - An ack/err arriving outside BUS is ignored.
- Reset mid-transfer: next edge cyc/stb=0, pending response discarded, state IDLE.
- Counter width clog2(TIMEOUT+1). It never wraps; it saturates at the abort.
- wbm_adr_o/dat_o/sel_o/we_o keep their last values when idle. Only cyc/stb are qualified.

Decomposition:
- Package wb_master_pkg: state encoding (IDLE, BUS, RESP) and status constants (ST_OK=2'b00, ST_BUSERR=2'b01, ST_TIMEOUT=2'b10).
- One sub-module, wb_timeout_ctr:
  - Inputs: clear, enable.
  - Output: expired, at count TIMEOUT-1.
  - Parameter: TIMEOUT.
- Main FSM and datapath registers stay in wb_cmd_master.

Test Plan:
- Write: cmd we=1 addr=0x3000_0000 wdata=0xDEAD_BEEF sel=4'hF; slave acks 1 cycle after STB -> wbm_dat_o=0xDEADBEEF with cyc/stb high 2 cycles; rsp_status=00, rsp_rdata=0, rsp_valid 3 edges after accept.
- Read: cmd we=0 addr=0x3000_0004; slave returns dat_i=0x0000_0012 with ack -> rsp_rdata=0x12, status 00; rsp held 5 cycles while rsp_ready=0, released on rsp_ready=1.
- Bus error: slave asserts ack and err together -> status 01, rdata 0, cyc/stb low the next cycle.
- Timeout with TIMEOUT=8: slave never responds -> cyc/stb high exactly 8 cycles, then status 10; ack arriving on cycle 8 instead -> status 00.
- Reset mid-BUS: assert reset on cycle 2 of a read -> cyc/stb=0 and rsp_valid=0 next edge, cmd_ready=1; a following write completes normally.
- Back-to-back: cmd_valid held high across 3 commands with rsp_ready=1 -> exactly 3 bus cycles and 3 responses in order, cmd_ready low between accept and response handshake.

Source files
------------

// File: rtl/wb_master_pkg.sv
// Shared encodings for the Wishbone command master: FSM states and the
// response status codes returned on the rsp channel.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_OK      = 2'b00;
  localparam status_t ST_BUSERR  = 2'b01;
  localparam status_t ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command/response handshake plus Wishbone master signals of wb_cmd_master.
// The master modport is the DUT view, the slave modport the opposite end.
interface wb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [SEL_W-1:0]  cmd_sel;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_status;

  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [SEL_W-1:0]  wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;
  logic              wbm_err_i;

  logic              busy;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    input  rsp_ready,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_status,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    output rsp_ready,
    output wbm_dat_i, wbm_ack_i, wbm_err_i,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_status,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  busy
  );

endinterface

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: counts enabled cycles from a clear and flags the last
// permitted cycle (TIMEOUT-1); it holds there instead of wrapping.
module wb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone B4 classic single-transfer initiator: one command in, one CYC/STB
// cycle on the bus, one response out, with a watchdog bounding the wait.
module wb_cmd_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  wb_cmd_master_if.master  bus
);

  localparam int SEL_W = DATA_W / 8;

  state_t            state_reg, state_next;
  logic              we_reg;
  logic [ADDR_W-1:0] adr_reg;
  logic [DATA_W-1:0] dat_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  status_t           status_reg, status_next;
  logic              accept;
  logic              expired;

  wb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state_reg == BUS),
    .expired(expired)
  );

  // Exit priority in BUS: err beats ack, and ack beats a same-cycle timeout.
  always_comb begin
    state_next  = state_reg;
    rdata_next  = rdata_reg;
    status_next = status_reg;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (bus.wbm_err_i) begin
          state_next  = RESP;
          rdata_next  = '0;
          status_next = ST_BUSERR;
        end else if (bus.wbm_ack_i) begin
          state_next  = RESP;
          rdata_next  = we_reg ? '0 : bus.wbm_dat_i;
          status_next = ST_OK;
        end else if (expired) begin
          state_next  = RESP;
          rdata_next  = '0;
          status_next = ST_TIMEOUT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      we_reg     <= 1'b0;
      adr_reg    <= '0;
      dat_reg    <= '0;
      sel_reg    <= '0;
      rdata_reg  <= '0;
      status_reg <= ST_OK;
    end else begin
      state_reg  <= state_next;
      rdata_reg  <= rdata_next;
      status_reg <= status_next;
      if (accept) begin
        we_reg  <= bus.cmd_we;
        adr_reg <= bus.cmd_addr;
        dat_reg <= bus.cmd_wdata;
        sel_reg <= bus.cmd_sel;
      end
    end
  end

  // CYC/STB and the handshakes follow the registered state directly; the
  // address/data/select/we lines simply keep their last command when idle.
  assign bus.cmd_ready  = (state_reg == IDLE);
  assign bus.busy       = (state_reg != IDLE);
  assign bus.wbm_cyc_o  = (state_reg == BUS);
  assign bus.wbm_stb_o  = (state_reg == BUS);
  assign bus.wbm_we_o   = we_reg;
  assign bus.wbm_adr_o  = adr_reg;
  assign bus.wbm_dat_o  = dat_reg;
  assign bus.wbm_sel_o  = sel_reg;
  assign bus.rsp_valid  = (state_reg == RESP);
  assign bus.rsp_rdata  = rdata_reg;
  assign bus.rsp_status = status_reg;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: directed commands against a small Wishbone slave
// model, with scoreboards for responses and for each bus cycle.
module tb_wb_cmd_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc_num = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_num <= cyc_num + 1;

  wb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

  wb_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.master)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          len;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  status;
  } rsp_exp_t;

  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int       n_bus = 0;

  // slave model knobs
  int          sl_delay = 0;
  logic        sl_err = 1'b0;
  logic [31:0] sl_rdata = 32'h0;
  int          sl_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Registered slave: answers sl_delay+1 edges after it first sees STB.
  always @(posedge clk) begin
    if (bus_if.wbm_cyc_o && bus_if.wbm_stb_o && !(bus_if.wbm_ack_i || bus_if.wbm_err_i)) begin
      if (sl_cnt == sl_delay) begin
        bus_if.wbm_ack_i <= 1'b1;
        bus_if.wbm_err_i <= sl_err;
      end
      sl_cnt <= sl_cnt + 1;
    end else begin
      bus_if.wbm_ack_i <= 1'b0;
      bus_if.wbm_err_i <= 1'b0;
      sl_cnt <= 0;
    end
  end
  assign bus_if.wbm_dat_i = sl_rdata;

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus_if.rsp_valid && bus_if.rsp_ready) begin
        chk("rsp_no_same_cycle_accept", {63'd0, bus_if.cmd_ready}, 64'd0);
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          rsp_exp_t e;
          e = rsp_q.pop_front();
          $display("rsp: rdata=%08h status=%02b (exp %08h %02b)",
                   bus_if.rsp_rdata, bus_if.rsp_status, e.rdata, e.status);
          chk("rsp_rdata", {32'd0, bus_if.rsp_rdata}, {32'd0, e.rdata});
          chk("rsp_status", {62'd0, bus_if.rsp_status}, {62'd0, e.status});
        end
      end
    end
  end

  // Bus-cycle monitor
  initial begin
    logic        in_cyc = 1'b0;
    logic        unstable = 1'b0;
    int          len = 0;
    logic        c_we;
    logic [31:0] c_adr, c_dat;
    logic [3:0]  c_sel;
    forever begin
      @(negedge clk);
      if (bus_if.wbm_cyc_o) begin
        if (!in_cyc) begin
          in_cyc = 1'b1; len = 0; unstable = 1'b0;
          c_we = bus_if.wbm_we_o; c_adr = bus_if.wbm_adr_o;
          c_dat = bus_if.wbm_dat_o; c_sel = bus_if.wbm_sel_o;
        end
        len++;
        if (bus_if.wbm_stb_o !== 1'b1 || bus_if.wbm_we_o !== c_we || bus_if.wbm_adr_o !== c_adr ||
            bus_if.wbm_dat_o !== c_dat || bus_if.wbm_sel_o !== c_sel)
          unstable = 1'b1;
      end else if (in_cyc) begin
        in_cyc = 1'b0;
        n_bus++;
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", 64'd1, 64'd0);
        end else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          $display("bus: we=%0b adr=%08h dat=%08h sel=%h cycles=%0d", c_we, c_adr, c_dat, c_sel, len);
          chk("bus_len", 64'(len), 64'(e.len));
          chk("bus_we", {63'd0, c_we}, {63'd0, e.we});
          chk("bus_adr", {32'd0, c_adr}, {32'd0, e.adr});
          chk("bus_dat", {32'd0, c_dat}, {32'd0, e.dat});
          chk("bus_sel", {60'd0, c_sel}, {60'd0, e.sel});
          chk("bus_stable", {63'd0, unstable}, 64'd0);
        end
      end
    end
  end

  task automatic set_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus_if.cmd_we = we;
    bus_if.cmd_addr = adr;
    bus_if.cmd_wdata = dat;
    bus_if.cmd_sel = sel;
  endtask

  // Waits (bounded) for an accepting cycle; base is cyc_num just before the accept edge.
  task automatic wait_accept(output int base);
    base = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.cmd_valid && bus_if.cmd_ready) begin
        base = cyc_num;
        break;
      end
    end
    if (base < 0) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic send_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output int base);
    set_cmd(we, adr, dat, sel);
    bus_if.cmd_valid = 1'b1;
    wait_accept(base);
    bus_if.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid) begin
        at = cyc_num;
        break;
      end
    end
    if (at < 0) chk("rsp_wait_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    int base, at, hold_ok, b0;
    logic        b_we[3]  = '{1'b1, 1'b0, 1'b1};
    logic [31:0] b_adr[3] = '{32'h3000_0010, 32'h3000_0014, 32'h3000_0018};
    logic [31:0] b_dat[3] = '{32'h1111_1111, 32'h0000_0000, 32'h2222_2222};
    logic [3:0]  b_sel[3] = '{4'hF, 4'hF, 4'hC};
    logic [31:0] b_rd[3]  = '{32'h0, 32'hA5A5_A5A5, 32'h0};

    bus_if.cmd_valid = 1'b0;
    bus_if.rsp_ready = 1'b0;
    bus_if.wbm_ack_i = 1'b0;
    bus_if.wbm_err_i = 1'b0;
    set_cmd(1'b0, 32'h0, 32'h0, 4'h0);
    idle_cycles(3);
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
    chk("reset_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    chk("reset_cyc_stb", {62'd0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 64'd0);
    chk("reset_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("reset_adr_dat", {bus_if.wbm_adr_o, bus_if.wbm_dat_o}, 64'd0);
    chk("reset_rsp_data", {30'd0, bus_if.rsp_status, bus_if.rsp_rdata}, 64'd0);
    @(posedge clk); #1;

    // write, slave acks one cycle after STB
    sl_delay = 0; sl_err = 1'b0; sl_rdata = 32'h7777_7777;
    bus_if.rsp_ready = 1'b1;
    bus_q.push_back('{1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 2});
    rsp_q.push_back('{32'h0, 2'b00});
    send_cmd(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, base);
    wait_rsp(at);
    chk("wr_latency_edges", 64'(at - base), 64'd3);
    idle_cycles(3);

    // read with 5 cycles of backpressure
    sl_rdata = 32'h0000_0012;
    bus_if.rsp_ready = 1'b0;
    bus_q.push_back('{1'b0, 32'h3000_0004, 32'h0, 4'hF, 2});
    rsp_q.push_back('{32'h0000_0012, 2'b00});
    send_cmd(1'b0, 32'h3000_0004, 32'h0, 4'hF, base);
    wait_rsp(at);
    hold_ok = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus_if.rsp_valid && bus_if.rsp_rdata == 32'h12 && bus_if.rsp_status == 2'b00) hold_ok++;
    end
    chk("rd_rsp_hold_cycles", 64'(hold_ok), 64'd5);
    @(posedge clk); #1;
    bus_if.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rd_rsp_released", {63'd0, bus_if.rsp_valid}, 64'd0);
    chk("rd_cmd_ready_back", {63'd0, bus_if.cmd_ready}, 64'd1);
    idle_cycles(2);

    // ack and err together: err wins
    sl_err = 1'b1; sl_rdata = 32'h0000_0012;
    bus_q.push_back('{1'b0, 32'h3000_0008, 32'h0, 4'hF, 2});
    rsp_q.push_back('{32'h0, 2'b01});
    send_cmd(1'b0, 32'h3000_0008, 32'h0, 4'hF, base);
    wait_rsp(at);
    idle_cycles(3);

    // timeout: slave silent, TIMEOUT=8
    sl_err = 1'b0; sl_delay = 1000;
    bus_q.push_back('{1'b0, 32'h3000_0020, 32'h0, 4'hF, 8});
    rsp_q.push_back('{32'h0, 2'b10});
    send_cmd(1'b0, 32'h3000_0020, 32'h0, 4'hF, base);
    wait_rsp(at);
    chk("timeout_rsp_edges", 64'(at - base), 64'd9);
    idle_cycles(3);

    // ack on the final timeout cycle: ack wins
    sl_delay = 6; sl_rdata = 32'h0000_55AA;
    bus_q.push_back('{1'b0, 32'h3000_0024, 32'h0, 4'hF, 8});
    rsp_q.push_back('{32'h0000_55AA, 2'b00});
    send_cmd(1'b0, 32'h3000_0024, 32'h0, 4'hF, base);
    wait_rsp(at);
    idle_cycles(3);

    // reset on cycle 2 of a read; response discarded
    sl_delay = 1000;
    bus_q.push_back('{1'b0, 32'h3000_000C, 32'h0, 4'hF, 2});
    send_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF, base);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_cyc_stb", {62'd0, bus_if.wbm_cyc_o, bus_if.wbm_stb_o}, 64'd0);
    chk("rst_mid_rsp_valid", {63'd0, bus_if.rsp_valid}, 64'd0);
    chk("rst_mid_cmd_ready", {63'd0, bus_if.cmd_ready}, 64'd1);
    idle_cycles(2);
    sl_delay = 0;
    bus_q.push_back('{1'b1, 32'h3000_0030, 32'hCAFE_F00D, 4'h3, 2});
    rsp_q.push_back('{32'h0, 2'b00});
    send_cmd(1'b1, 32'h3000_0030, 32'hCAFE_F00D, 4'h3, base);
    wait_rsp(at);
    idle_cycles(3);
    chk("idle_adr_kept", {32'd0, bus_if.wbm_adr_o}, {32'd0, 32'h3000_0030});

    // back-to-back with cmd_valid held high
    sl_rdata = 32'hA5A5_A5A5;
    b0 = n_bus;
    for (int k = 0; k < 3; k++) begin
      bus_q.push_back('{b_we[k], b_adr[k], b_dat[k], b_sel[k], 2});
      rsp_q.push_back('{b_rd[k], 2'b00});
    end
    set_cmd(b_we[0], b_adr[0], b_dat[0], b_sel[0]);
    bus_if.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_accept(base);
      if (k < 2) set_cmd(b_we[k+1], b_adr[k+1], b_dat[k+1], b_sel[k+1]);
      else bus_if.cmd_valid = 1'b0;
    end
    idle_cycles(8);
    chk("b2b_bus_cycles", 64'(n_bus - b0), 64'd3);

    chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
